// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and SoC address-map constants.
// Also holds a helper that packs a character byte into a bus word.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // SoC address map: VGA text peripheral character data register
    localparam logic [31:0] VGA_BASE_ADDR = 32'h5000_0000;

    function automatic logic [31:0] char_to_word(input logic [7:0] c);
        return {24'h00_0000, c};
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Small synchronous FIFO for character bytes; power-of-2 depth,
// pointers wrap naturally and full/empty come from an occupancy count.
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; guarded ops make overflow/underflow no-ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

endmodule

// File: rtl/ahb_vga_char_initiator.sv
// AHB-Lite master that drains a character FIFO into the VGA data register,
// one pipelined single-beat word write per byte.
module ahb_vga_char_initiator
    import ahb_lite_pkg::*;
#(
    parameter logic [31:0] VGA_ADDR   = VGA_BASE_ADDR,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic             HRESP,
    input  logic             err_clr,
    output logic             err_flag,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]    count_s;
    logic [CW-1:0]    count_next_s;
    logic [7:0]       head_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             pending_next_s;

    htrans_e          htrans_r;
    logic [31:0]      haddr_r;
    logic             hwrite_r;
    logic [2:0]       hsize_r;
    logic [31:0]      hwdata_r;
    logic             pending_r;
    logic             err_r;
    logic             in_ready_r;
    logic             busy_r;
    logic [CNT_W-1:0] xfer_count_r;

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (push_s),
        .din   (in_data),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign push_s = in_valid && in_ready_r && !full_s;
    assign pop_s  = (htrans_r == HTRANS_NONSEQ) && HREADY && !empty_s;

    // Occupancy after this edge, and whether a data phase is open after it
    always_comb begin
        count_next_s = count_s + CW'(push_s) - CW'(pop_s);
        if (HREADY) begin
            pending_next_s = pop_s;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // Bus phase registers, sticky error, counter and registered status outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            htrans_r     <= HTRANS_IDLE;
            haddr_r      <= 32'h0000_0000;
            hwrite_r     <= 1'b0;
            hsize_r      <= HSIZE_BYTE;
            hwdata_r     <= 32'h0000_0000;
            pending_r    <= 1'b0;
            err_r        <= 1'b0;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            xfer_count_r <= {CNT_W{1'b0}};
        end else begin
            in_ready_r <= (count_next_s != CW'(FIFO_DEPTH));
            busy_r     <= (count_next_s != {CW{1'b0}}) || pending_next_s;
            // Error set has priority over clear so a same-edge error is never lost
            if ((HRESP == HRESP_ERROR) && pending_r) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end
            if (HREADY) begin
                pending_r <= pop_s;
                if (pop_s) begin
                    hwdata_r <= char_to_word(head_s);
                end
                if (pending_r) begin
                    xfer_count_r <= xfer_count_r + 1'b1;
                end
                if (count_next_s != {CW{1'b0}}) begin
                    htrans_r <= HTRANS_NONSEQ;
                    haddr_r  <= VGA_ADDR;
                    hwrite_r <= 1'b1;
                    hsize_r  <= HSIZE_WORD;
                end else begin
                    htrans_r <= HTRANS_IDLE;
                    hwrite_r <= 1'b0;
                    hsize_r  <= HSIZE_BYTE;
                end
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign HADDR      = haddr_r;
    assign HTRANS     = htrans_r;
    assign HWRITE     = hwrite_r;
    assign HSIZE      = hsize_r;
    assign HWDATA     = hwdata_r;
    assign err_flag   = err_r;
    assign busy       = busy_r;
    assign xfer_count = xfer_count_r;

endmodule

// File: tb/tb_ahb_vga_char_initiator.sv
// Directed bench for ahb_vga_char_initiator with hand-computed expectations.
module tb_ahb_vga_char_initiator;

    logic        HCLK;
    logic        HRESETn;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic        err_clr;
    logic        err_flag;
    logic        busy;
    logic [15:0] xfer_count;

    int n_chk  = 0;
    int n_pass = 0;

    ahb_vga_char_initiator dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .err_clr    (err_clr),
        .err_flag   (err_flag),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESETn  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        err_clr  = 1'b0;
        step();
        step();
        HRESETn = 1'b1;
        step();
    endtask

    logic [7:0] burst [4];
    logic [7:0] exp_bp [5];

    initial begin
        burst  = '{8'h48, 8'h45, 8'h4C, 8'h4F};
        exp_bp = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64};
        HRESETn  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        err_clr  = 1'b0;

        // Reset state while reset is held
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_htrans",   {30'd0, HTRANS},   32'd0);
        chk("rst_hwdata",   HWDATA,            32'd0);
        chk("rst_haddr",    HADDR,             32'd0);
        chk("rst_err",      {31'd0, err_flag}, 32'd0);
        chk("rst_xfer",     {16'd0, xfer_count}, 32'd0);
        do_reset();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_busy",     {31'd0, busy},     32'd0);

        // Single byte
        in_valid = 1'b1;
        in_data  = 8'h41;
        step();
        in_valid = 1'b0;
        chk("single_htrans", {30'd0, HTRANS}, 32'd2);
        chk("single_haddr",  HADDR,           32'h5000_0000);
        chk("single_hwrite", {31'd0, HWRITE}, 32'd1);
        chk("single_hsize",  {29'd0, HSIZE},  32'd2);
        chk("single_busy1",  {31'd0, busy},   32'd1);
        step();
        chk("single_hwdata", HWDATA,          32'h0000_0041);
        chk("single_idle",   {30'd0, HTRANS}, 32'd0);
        chk("single_hsize0", {29'd0, HSIZE},  32'd0);
        step();
        chk("single_xfer",   {16'd0, xfer_count}, 32'd1);
        chk("single_busy0",  {31'd0, busy},       32'd0);

        // Burst of four back-to-back bytes
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                in_valid = 1'b1;
                in_data  = burst[i];
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i < 4) chk("burst_nonseq", {30'd0, HTRANS}, 32'd2);
            else if (i == 4) chk("burst_idle", {30'd0, HTRANS}, 32'd0);
            if ((i >= 1) && (i <= 4)) chk("burst_hwdata", HWDATA, {24'd0, burst[i-1]});
        end
        chk("burst_xfer", {16'd0, xfer_count}, 32'd4);

        // Wait states during the data phase of byte 2
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h31 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        HREADY   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_hwdata", HWDATA,          32'h0000_0032);
            chk("ws_htrans", {30'd0, HTRANS}, 32'd2);
            chk("ws_haddr",  HADDR,           32'h5000_0000);
            chk("ws_xfer",   {16'd0, xfer_count}, 32'd1);
        end
        HREADY = 1'b1;
        step();
        chk("ws_hwdata3", HWDATA,          32'h0000_0033);
        chk("ws_idle",    {30'd0, HTRANS}, 32'd0);
        step();
        chk("ws_xfer3",   {16'd0, xfer_count}, 32'd3);
        chk("ws_busy0",   {31'd0, busy},       32'd0);

        // Backpressure: fill the FIFO with the bus stalled
        do_reset();
        HREADY   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = exp_bp[i];
            step();
            chk("bp_in_ready", {31'd0, in_ready}, (i < 3) ? 32'd1 : 32'd0);
        end
        in_data = exp_bp[4];
        step();
        chk("bp_held_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_held_idle",  {30'd0, HTRANS},   32'd0);
        HREADY = 1'b1;
        step();
        chk("bp_nonseq",     {30'd0, HTRANS},   32'd2);
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        step();
        chk("bp_hwdata0",    HWDATA,            32'h0000_0060);
        chk("bp_ready_pop",  {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_hwdata1",    HWDATA,            32'h0000_0061);
        for (int i = 2; i < 5; i++) begin
            step();
            chk("bp_hwdata", HWDATA, {24'd0, exp_bp[i]});
        end
        chk("bp_idle",  {30'd0, HTRANS},       32'd0);
        step();
        chk("bp_xfer",  {16'd0, xfer_count},   32'd5);

        // Error response on byte 1 of 2, set-wins-over-clear, then clear
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hA1;
        step();
        in_data  = 8'hA2;
        step();
        in_valid = 1'b0;
        HREADY   = 1'b0;
        HRESP    = 1'b1;
        step();
        chk("err_first",     {31'd0, err_flag}, 32'd1);
        chk("err_hold_data", HWDATA,            32'h0000_00A1);
        chk("err_hold_addr", {30'd0, HTRANS},   32'd2);
        HREADY  = 1'b1;
        err_clr = 1'b1;
        step();
        chk("err_set_wins",  {31'd0, err_flag}, 32'd1);
        chk("err_byte2",     HWDATA,            32'h0000_00A2);
        HRESP   = 1'b0;
        err_clr = 1'b0;
        step();
        chk("err_sticky",    {31'd0, err_flag},   32'd1);
        chk("err_xfer",      {16'd0, xfer_count}, 32'd2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_cleared",   {31'd0, err_flag},   32'd0);

        // Reset mid-operation with bytes queued and the bus stalled
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hB1;
        step();
        in_data  = 8'hB2;
        step();
        HREADY   = 1'b0;
        in_data  = 8'hB3;
        step();
        in_data  = 8'hB4;
        step();
        in_valid = 1'b0;
        chk("mid_pre_hwdata", HWDATA,          32'h0000_00B1);
        chk("mid_pre_htrans", {30'd0, HTRANS}, 32'd2);
        HRESETn = 1'b0;
        #1;
        chk("mid_async_htrans", {30'd0, HTRANS}, 32'd0);
        chk("mid_async_hwdata", HWDATA,          32'd0);
        chk("mid_async_busy",   {31'd0, busy},   32'd0);
        step();
        HREADY  = 1'b1;
        HRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_stale", {30'd0, HTRANS}, 32'd0);
        end
        chk("mid_xfer", {16'd0, xfer_count}, 32'd0);
        chk("mid_busy", {31'd0, busy},       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
